// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and lowest-index issue.
// Define ALU_RS_BYPASS_EN to capture a same-cycle CDB result at dispatch.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [3:0]           in_op,
  input  logic [31:0]          in_vj,
  input  logic [31:0]          in_vk,
  input  logic                 in_qj_valid,
  input  logic                 in_qk_valid,
  input  logic [ROB_WIDTH-1:0] in_qj,
  input  logic [ROB_WIDTH-1:0] in_qk,
  input  logic [ROB_WIDTH-1:0] in_dest,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  output logic                 full,
  output logic                 cal,
  output logic [31:0]          a,
  output logic [31:0]          b,
  output logic [3:0]           alu_op,
  output logic [ROB_WIDTH-1:0] alu_dest
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_qjv;
  logic [RS_SIZE-1:0]   r_qkv;
  logic [3:0]           r_op   [RS_SIZE];
  logic [31:0]          r_vj   [RS_SIZE];
  logic [31:0]          r_vk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qj   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qk   [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_dest [RS_SIZE];

  logic                 r_full;
  logic                 r_cal;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [3:0]           r_op_o;
  logic [ROB_WIDTH-1:0] r_dest_o;

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_wj;
  logic [RS_SIZE-1:0] w_wk;
  logic [RS_SIZE-1:0] w_busy_nxt;
  logic [IW-1:0]      w_free_idx;
  logic [IW-1:0]      w_iss_idx;
  logic               w_free_ok;
  logic               w_iss_ok;
  logic               w_disp;
  logic [CW-1:0]      w_cnt;
  logic               w_djv;
  logic               w_dkv;
  logic [31:0]        w_dvj;
  logic [31:0]        w_dvk;

  assign full     = r_full;
  assign cal      = r_cal;
  assign a        = r_a;
  assign b        = r_b;
  assign alu_op   = r_op_o;
  assign alu_dest = r_dest_o;

  // Readiness and CDB tag matches, from registered entry state only
  always_comb begin
    w_ready = '0;
    w_wj    = '0;
    w_wk    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] & ~r_qjv[i] & ~r_qkv[i];
      w_wj[i]    = cdb_valid & r_busy[i] & r_qjv[i]
                 & (r_qj[i] == cdb_tag);
      w_wk[i]    = cdb_valid & r_busy[i] & r_qkv[i]
                 & (r_qk[i] == cdb_tag);
    end
  end

  // Lowest-index free slot and lowest-index ready entry
  always_comb begin
    w_free_ok  = 1'b0;
    w_free_idx = '0;
    w_iss_ok   = 1'b0;
    w_iss_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_ok  = 1'b1;
        w_free_idx = IW'(i);
      end
      if (w_ready[i]) begin
        w_iss_ok  = 1'b1;
        w_iss_idx = IW'(i);
      end
    end
  end

  // Operand capture at dispatch, optionally bypassing the live CDB
  always_comb begin
    w_djv = in_qj_valid;
    w_dkv = in_qk_valid;
    w_dvj = in_vj;
    w_dvk = in_vk;
`ifdef ALU_RS_BYPASS_EN
    if (in_qj_valid && cdb_valid && in_qj == cdb_tag) begin
      w_djv = 1'b0;
      w_dvj = cdb_value;
    end
    if (in_qk_valid && cdb_valid && in_qk == cdb_tag) begin
      w_dkv = 1'b0;
      w_dvk = cdb_value;
    end
`endif
  end

  // Busy vector after this edge and its population count
  always_comb begin
    w_disp     = in_valid & ~r_full & w_free_ok;
    w_busy_nxt = r_busy;
    if (w_iss_ok) w_busy_nxt[w_iss_idx] = 1'b0;
    if (w_disp) w_busy_nxt[w_free_idx] = 1'b1;
    w_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_cnt = w_cnt + CW'(w_busy_nxt[i]);
    end
  end

  // Control state and issue payload registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy   <= '0;
      r_full   <= 1'b0;
      r_cal    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op_o   <= '0;
      r_dest_o <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy <= '0;
        r_full <= 1'b0;
        r_cal  <= 1'b0;
      end else begin
        r_busy <= w_busy_nxt;
        r_full <= (w_cnt == CW'(RS_SIZE));
        r_cal  <= w_iss_ok;
        if (w_iss_ok) begin
          r_a      <= r_vj[w_iss_idx];
          r_b      <= r_vk[w_iss_idx];
          r_op_o   <= r_op[w_iss_idx];
          r_dest_o <= r_dest[w_iss_idx];
        end
      end
    end
  end

  // Entry payload: dispatch write into a free slot, wakeup on busy slots
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_disp && w_free_idx == IW'(i)) begin
          r_op[i]   <= in_op;
          r_vj[i]   <= w_dvj;
          r_vk[i]   <= w_dvk;
          r_qjv[i]  <= w_djv;
          r_qkv[i]  <= w_dkv;
          r_qj[i]   <= in_qj;
          r_qk[i]   <= in_qk;
          r_dest[i] <= in_dest;
        end else begin
          if (w_wj[i]) begin
            r_vj[i]  <= cdb_value;
            r_qjv[i] <= 1'b0;
          end
          if (w_wk[i]) begin
            r_vk[i]  <= cdb_value;
            r_qkv[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed stimulus with a queue scoreboard for alu_rs issues.
// Monitor pops one expected issue per enabled edge that raises cal.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic        in_qj_valid;
  logic        in_qk_valid;
  logic [3:0]  in_qj;
  logic [3:0]  in_qk;
  logic [3:0]  in_dest;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        full;
  logic        cal;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic [3:0]  alu_dest;

  int n_chk  = 0;
  int n_fail = 0;
  bit r_en   = 1'b0;
  logic [71:0] sb[$];

  alu_rs #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear(clear), .in_valid(in_valid), .in_op(in_op),
    .in_vj(in_vj), .in_vk(in_vk),
    .in_qj_valid(in_qj_valid), .in_qk_valid(in_qk_valid),
    .in_qj(in_qj), .in_qk(in_qk), .in_dest(in_dest),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .full(full), .cal(cal),
    .a(a), .b(b), .alu_op(alu_op), .alu_dest(alu_dest)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Was the last edge an enabled, non-reset edge?
  always @(posedge clk_in) r_en <= rdy_in && !rst_in;

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (r_en && cal === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", {a, b, alu_op, alu_dest}, '0);
        if ({a, b, alu_op, alu_dest} == '0) begin
          n_fail++;
          $display("FAIL unexpected_issue: got zero payload expected none");
        end
      end else begin
        chk("issue_payload", {a, b, alu_op, alu_dest}, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] vj,
                      input logic [31:0] vk, input logic qjv,
                      input logic [3:0] qj, input logic qkv,
                      input logic [3:0] qk, input logic [3:0] dest);
    in_valid    = 1'b1;
    in_op       = op;
    in_vj       = vj;
    in_vk       = vk;
    in_qj_valid = qjv;
    in_qj       = qj;
    in_qk_valid = qkv;
    in_qk       = qk;
    in_dest     = dest;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
  endtask

  function automatic logic [71:0] pay(input logic [31:0] va,
      input logic [31:0] vb, input logic [3:0] op, input logic [3:0] d);
    return {va, vb, op, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_op = '0; in_vj = '0; in_vk = '0;
    in_qj_valid = 1'b0; in_qk_valid = 1'b0;
    in_qj = '0; in_qk = '0; in_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    tick(); tick();
    chk("rst_full", full, 0);
    chk("rst_cal", cal, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_dest", alu_dest, 0);
    rst_in = 1'b0;

    // Ready-at-dispatch ADD
    disp(4'd0, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
    sb.push_back(pay(5, 7, 0, 3));
    tick();
    chk("add_cal_e0", cal, 0);
    tick();
    chk("add_cal_e1", cal, 1);
    chk("add_a_e1", a, 5);
    tick();
    chk("add_cal_e2", cal, 0);

    // Hold under rdy_in=0
    disp(4'd2, 32'hF0, 32'h0F, 0, 0, 0, 0, 4'd7);
    sb.push_back(pay(32'hF0, 32'h0F, 2, 7));
    tick(); tick();
    chk("hold_cal_pre", cal, 1);
    rdy_in = 1'b0;
    disp(4'd3, 32'd1, 32'd2, 0, 0, 0, 0, 4'd8);
    bcast(4'd1, 32'd99);
    tick();
    chk("hold_cal", cal, 1);
    chk("hold_a", a, 32'hF0);
    chk("hold_dest", alu_dest, 7);
    chk("hold_full", full, 0);
    rdy_in = 1'b1;
    tick();
    chk("hold_drop_cal", cal, 0);
    tick();
    chk("hold_drop_cal2", cal, 0);

    // Pending j operand woken by CDB
    disp(4'd1, 32'hDEAD, 32'd3, 1, 4'd2, 0, 0, 4'd5);
    tick();
    tick();
    chk("wk_idle1", cal, 0);
    tick();
    chk("wk_idle2", cal, 0);
    bcast(4'd2, 32'h10);
    sb.push_back(pay(32'h10, 3, 1, 5));
    tick();
    chk("wk_wake_edge", cal, 0);
    tick();
    chk("wk_issue", cal, 1);
    chk("wk_a", a, 32'h10);

    // Fill all eight entries with pending operands
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 32'd0, 32'(100 + i), 1, 4'(8 + i), 0, 0, 4'(i));
      tick();
      if (i == 6) chk("full_at7", full, 0);
    end
    chk("full_at8", full, 1);
    disp(4'd0, 32'd1, 32'd1, 0, 0, 0, 0, 4'd15);
    tick();
    chk("full_ignore_full", full, 1);
    chk("full_ignore_cal", cal, 0);
    bcast(4'd11, 32'hAA);
    sb.push_back(pay(32'hAA, 103, 3, 3));
    tick();
    chk("full_wake_full", full, 1);
    disp(4'd0, 32'd1, 32'd1, 0, 0, 0, 0, 4'd14);
    tick();
    chk("full_issue_cal", cal, 1);
    chk("full_issue_full", full, 0);
    tick();
    chk("full_after_cal", cal, 0);
    clear = 1'b1;
    tick();
    chk("flush_full", full, 0);
    for (int t = 8; t < 16; t++) begin
      bcast(4'(t), 32'h77);
      tick();
    end
    tick(); tick();
    chk("flush_empty_cal", cal, 0);

    // Simultaneous wakeup of entries 1 and 4
    disp(4'd0, 0, 32'd10, 1, 4'd1, 0, 0, 4'd0); tick();
    disp(4'd1, 0, 32'd11, 1, 4'd2, 0, 0, 4'd1); tick();
    disp(4'd2, 0, 32'd12, 1, 4'd3, 0, 0, 4'd2); tick();
    disp(4'd3, 0, 32'd13, 1, 4'd4, 0, 0, 4'd3); tick();
    disp(4'd4, 0, 32'd14, 1, 4'd2, 0, 0, 4'd4); tick();
    bcast(4'd2, 32'h22);
    sb.push_back(pay(32'h22, 11, 1, 1));
    tick();
    disp(4'd7, 32'h55, 32'h56, 0, 0, 0, 0, 4'd5);
    bcast(4'd1, 32'h11);
    sb.push_back(pay(32'h11, 10, 0, 0));
    sb.push_back(pay(32'h22, 14, 4, 4));
    sb.push_back(pay(32'h55, 32'h56, 7, 5));
    tick();
    chk("pri_first", alu_dest, 1);
    tick();
    chk("pri_second", alu_dest, 0);
    tick();
    chk("pri_third", alu_dest, 4);
    tick();
    chk("pri_fourth", alu_dest, 5);
    tick();
    chk("pri_done", cal, 0);

    // Clear behaviour; entries 2 and 3 still pending on tags 3 and 4
    disp(4'd5, 0, 32'd20, 1, 4'd6, 0, 0, 4'd6); tick();
    rdy_in = 1'b0;
    clear  = 1'b1;
    bcast(4'd3, 32'h99);
    tick();
    chk("clr_off_cal", cal, 0);
    chk("clr_off_full", full, 0);
    rdy_in = 1'b1;
    bcast(4'd3, 32'h33);
    sb.push_back(pay(32'h33, 12, 2, 2));
    tick(); tick();
    chk("clr_survivor", alu_dest, 2);
    disp(4'd6, 0, 32'd21, 1, 4'd7, 0, 0, 4'd9); tick();
    clear = 1'b1;
    disp(4'd0, 32'd1, 32'd2, 0, 0, 0, 0, 4'd10);
    bcast(4'd4, 32'h44);
    tick();
    chk("clr_cal", cal, 0);
    chk("clr_full", full, 0);
    bcast(4'd4, 32'h44); tick();
    bcast(4'd6, 32'h66); tick();
    bcast(4'd7, 32'h77); tick();
    tick();
    chk("clr_quiet", cal, 0);

    // Reset with an issue-ready entry pending
    disp(4'd9, 32'd8, 32'd9, 0, 0, 0, 0, 4'd11);
    tick();
    rst_in = 1'b1;
    tick();
    chk("mid_rst_cal", cal, 0);
    chk("mid_rst_a", a, 0);
    rst_in = 1'b0;
    tick();
    chk("mid_rst_drop", cal, 0);

`ifdef ALU_RS_BYPASS_EN
    disp(4'd0, 32'd4, 32'hBAD, 0, 0, 1, 4'd5, 4'd2);
    bcast(4'd5, 32'd9);
    sb.push_back(pay(4, 9, 0, 2));
    tick(); tick();
    chk("byp_cal", cal, 1);
    chk("byp_b", b, 9);
`endif

    tick(); tick();
    chk("sb_drained", 72'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
